// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS datapath and its controller:
// ALU operation codes, operand/PC-source select encodings and opcodes.
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_HOLD   = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  function automatic logic [31:0] sign_extend16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one write port,
// asynchronous active-low clear. Register 0 always reads zero and ignores
// writes. With MIPS_DBG_PORT_EN defined a third read port (dbg_ra/dbg_rd)
// is added for observation from benches.
module mips_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
`ifdef MIPS_DBG_PORT_EN
  input  logic [4:0]  dbg_ra,
  output logic [31:0] dbg_rd,
`endif
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [32];

  // Clear everything on reset; otherwise write at the edge, never to $0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

`ifdef MIPS_DBG_PORT_EN
  assign dbg_rd = (dbg_ra == 5'd0) ? 32'd0 : regs[dbg_ra];
`endif

endmodule

// File: rtl/mips_multicycle_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, register file and
// ALU, steered by controller strobes. Returns op/funct/zero to the
// controller and drives a unified instruction/data memory.
// Optional macro MIPS_DBG_PORT_EN adds a debug register read port.
module mips_multicycle_datapath
  import mips_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcen,
  input  logic             irwrite,
  input  logic             regwrite,
  input  logic             alusrca,
  input  logic [1:0]       alusrcb,
  input  logic             iord,
  input  logic             memtoreg,
  input  logic             regdst,
  input  logic [1:0]       pcsrc,
  input  logic [2:0]       alucontrol,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] readdata,
`ifdef MIPS_DBG_PORT_EN
  input  logic [4:0]       dbg_ra,
  output logic [WIDTH-1:0] dbg_rd,
`endif
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic             zero,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata,
  output logic             mem_we
);

  logic [31:0] pc, ir, mdr, a, b, aluout;
  logic [31:0] rd1, rd2;
  logic [31:0] srca, srcb, signimm, aluresult, pcnext, wd3;
  logic [4:0]  wa3;

  assign signimm = sign_extend16(ir[15:0]);
  assign wa3     = regdst ? ir[15:11] : ir[20:16];
  assign wd3     = memtoreg ? mdr : aluout;

  mips_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (regwrite),
    .ra1   (ir[25:21]),
    .ra2   (ir[20:16]),
    .wa    (wa3),
    .wd    (wd3),
`ifdef MIPS_DBG_PORT_EN
    .dbg_ra(dbg_ra),
    .dbg_rd(dbg_rd),
`endif
    .rd1   (rd1),
    .rd2   (rd2)
  );

  assign srca = alusrca ? a : pc;

  // Second ALU operand: B, +4 for PC increment, or the immediate forms
  always_comb begin
    srcb = b;
    case (alusrcb)
      SRCB_B:     srcb = b;
      SRCB_FOUR:  srcb = 32'd4;
      SRCB_IMM:   srcb = signimm;
      SRCB_IMMSH: srcb = {signimm[29:0], 2'b00};
      default:    srcb = b;
    endcase
  end

  // ALU; unused operation codes yield zero so the zero flag is set
  always_comb begin
    aluresult = 32'd0;
    case (alucontrol)
      ALU_ADD: aluresult = srca + srcb;
      ALU_SUB: aluresult = srca - srcb;
      ALU_AND: aluresult = srca & srcb;
      ALU_OR:  aluresult = srca | srcb;
      ALU_SLT: aluresult = {31'd0, $signed(srca) < $signed(srcb)};
      default: aluresult = 32'd0;
    endcase
  end

  assign zero = (aluresult == 32'd0);

  // Next PC source; the reserved select keeps the PC where it is
  always_comb begin
    pcnext = pc;
    case (pcsrc)
      PCSRC_ALU:    pcnext = aluresult;
      PCSRC_ALUOUT: pcnext = aluout;
      PCSRC_JUMP:   pcnext = {pc[31:28], ir[25:0], 2'b00};
      PCSRC_HOLD:   pcnext = pc;
      default:      pcnext = pc;
    endcase
  end

  // Architectural and pipeline-holding registers; A/B see pre-write values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      mdr    <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
    end else begin
      mdr    <= readdata;
      a      <= rd1;
      b      <= rd2;
      aluout <= aluresult;
      if (irwrite) ir <= readdata;
      if (pcen)    pc <= pcnext;
    end
  end

  assign op        = ir[31:26];
  assign funct     = ir[5:0];
  assign adr       = iord ? aluout : pc;
  assign writedata = b;
  assign mem_we    = memwrite;

endmodule

// File: doc/mips_multicycle_datapath.md
Name: mips_multicycle_datapath

Overview:
- Datapath end of the multicycle controller interface: consumes controller strobes, returns op/funct/zero.
- Holds PC, IR, MDR, A, B, ALUOut, a 32x32 register file and the ALU.
- Drives a unified external instruction/data memory.
- Sits beside the controller under the top-level MIPS processor.

Parameters:
- WIDTH, 32, data/address width (only 32 is supported).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge active
- reset  in  1  asynchronous, active-low; low clears all state
- pcen  in  1  PC write enable
- irwrite  in  1  IR write enable
- regwrite  in  1  register file write enable
- alusrca  in  1  0: ALU A = PC; 1: ALU A = A register
- alusrcb  in  2  00: B; 01: constant 4; 10: signimm; 11: signimm<<2
- iord  in  1  0: adr = PC; 1: adr = ALUOut
- memtoreg  in  1  0: write-back ALUOut; 1: write-back MDR
- regdst  in  1  0: destination rt; 1: destination rd
- pcsrc  in  2  00: ALU result; 01: ALUOut; 10: jump target; 11: reserved
- alucontrol  in  3  ALU operation select
- memwrite  in  1  pass-through to memory
- readdata  in  32  memory read data, combinational
- op  out  6  IR[31:26]
- funct  out  6  IR[5:0]
- zero  out  1  (ALU result == 0), combinational
- adr  out  32  memory address
- writedata  out  32  B register
- mem_we  out  1  equals memwrite

Behaviour:
Reset
- While reset is low (asynchronous): PC = RESET_PC; IR, MDR, A, B, ALUOut and all 32 registers = 0.
- Consequently op = 0, funct = 0, adr = RESET_PC, writedata = 0.

Every rising edge
- MDR <= readdata.
- A <= rf[IR[25:21]]; B <= rf[IR[20:16]].
- ALUOut <= ALU result.
- IR <= readdata only when irwrite = 1.
- PC <= PC-next only when pcen = 1.

Register file
- Read is combinational; write occurs at the edge.
- Read and write of the same register in one cycle: A/B capture the old value (no bypass).
- Register 0 reads 0 always; writes to it are discarded.

ALU
- 010 add, 110 sub, 000 and, 001 or, 111 slt (signed, result 1 or 0).
- Undefined codes (011, 100, 101) produce 0, so zero = 1.
- add/sub wrap modulo 2^32; no overflow flag.

Immediates and PC-next
- signimm = sign-extended IR[15:0].
- Jump target = {PC[31:28], IR[25:0], 2'b00}.
- pcsrc = 11 with pcen = 1: PC holds its value.

Latency
- Fetch: IR is valid the cycle after irwrite; op/funct follow IR with no added delay.
- zero is valid in the same cycle as the ALU operands.

Reset mid-instruction
- Partial state is discarded; the next fetch is from RESET_PC.
- op reads 0 (R-type encoding) during reset; the controller's own reset governs its sequence.

Optional Feature:
- Macro: MIPS_DBG_PORT_EN.
- Defined: adds input dbg_ra[4:0] and output dbg_rd[31:0], a third combinational read port on the register file (register 0 reads 0) for benches.
- Undefined: neither port exists; the register file has two read ports only.

Decomposition:
- Shared package mips_pkg holds:
  - alucontrol encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT);
  - alusrcb and pcsrc select constants;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J).
- One natural sub-module: mips_regfile (32x32, two read ports plus the optional debug port, one write port, asynchronous active-low clear).
- ALU and muxes stay inline.

Test Plan:
1. Reset low mid-cycle with PC = 0x40 -> PC, adr and op become 0 immediately (no clock needed); after release, adr = RESET_PC.
2. Fetch: readdata = 0x2008_0005 (addi $8,$0,5), irwrite = 1, pcen = 1, alusrca = 0, alusrcb = 01, alucontrol = 010, pcsrc = 00 -> next cycle op = 6'b001000, PC = 4.
3. addi execute/write-back: alusrca = 1, alusrcb = 10, then regwrite = 1, regdst = 0, memtoreg = 0 -> rf[8] = 5 (check with dbg_ra = 8 when MIPS_DBG_PORT_EN is defined).
4. beq with A = B = 7: alucontrol = 110 -> zero = 1. Target = ALUOut = PC + (imm<<2), with pcsrc = 01 -> PC updates to the target.
5. Jump: IR = 0x0800_0010, PC = 0x1000_0004, pcsrc = 10, pcen = 1 -> PC = 0x1000_0040.
6. Write to $0 (regwrite = 1, rd = 0, ALUOut = 0xFFFF_FFFF) -> rf[0] still reads 0. slt with A = 0xFFFF_FFFF, B = 1 -> ALU result = 1, zero = 0.
